// File: rtl/semis_cmp_pkg.sv
// semis_cmp_pkg: shared types, default sizing and small helpers for the
// multi-channel clocked comparator front end.
package semis_cmp_pkg;

    // Filter advance policy selected by the mode pin.
    typedef enum logic {
        CONTINUOUS = 1'b0,
        STROBED    = 1'b1
    } mode_e;

    // Per-channel debounce state.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } chan_state_e;

    // Default sizing of the array.
    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_DEB_W       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // A synchronised pair proposes a new decision only when it is not at a
    // tie; the proposal is vip_s itself (vip_s=1/vin_s=0 -> 1, 0/1 -> 0).
    // Returns 1 when the pair carries a candidate that differs from cur.
    function automatic logic cand_differs(
        input logic vip_s,
        input logic vin_s,
        input logic cur
    );
        logic differs;
        if (vip_s != vin_s) begin
            differs = (vip_s != cur);
        end else begin
            differs = 1'b0;
        end
        return differs;
    endfunction

    // Advance qualifier: the filter moves every cycle in continuous mode and
    // only on strobe cycles in strobed mode, and never while disabled.
    function automatic logic advance_ok(
        input logic ena,
        input logic mode,
        input logic strobe
    );
        logic adv;
        if (!ena) begin
            adv = 1'b0;
        end else if (mode_e'(mode) == CONTINUOUS) begin
            adv = 1'b1;
        end else begin
            adv = strobe;
        end
        return adv;
    endfunction

endpackage

// File: rtl/semis_cmp_channel.sv
// semis_cmp_channel: one comparator channel. Synchronises the asynchronous
// vip/vin pair, derives a candidate decision, and debounces it with a
// STABLE/PENDING state machine and a saturating run counter.
module semis_cmp_channel
    import semis_cmp_pkg::*;
#(
    parameter int DEB_W       = DEF_DEB_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic [DEB_W-1:0] deb_len,
    input  logic             vip,
    input  logic             vin,
    output logic             cmp_out,
    output logic             changed,
    output logic             tie
);

    // Synchroniser chains; bit 0 is the first stage, the top bit is the
    // metastability-safe output.
    logic [SYNC_STAGES-1:0] vip_sync_d;
    logic [SYNC_STAGES-1:0] vip_sync_q;
    logic [SYNC_STAGES-1:0] vin_sync_d;
    logic [SYNC_STAGES-1:0] vin_sync_q;
    logic                   vip_s;
    logic                   vin_s;

    // Debounce state.
    chan_state_e            state_d;
    chan_state_e            state_q;
    logic [DEB_W-1:0]       cnt_d;
    logic [DEB_W-1:0]       cnt_q;
    logic                   cmp_d;
    logic                   cmp_q;
    logic                   changed_d;
    logic                   changed_q;
    logic                   differs_s;
    logic [DEB_W-1:0]       cnt_inc_s;

    // Shift the raw pins into the synchroniser chains (runs regardless of ena).
    always_comb begin
        vip_sync_d = {vip_sync_q[SYNC_STAGES-2:0], vip};
        vin_sync_d = {vin_sync_q[SYNC_STAGES-2:0], vin};
    end

    // Synchroniser flops, cleared by reset so tie reads high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vip_sync_q <= {SYNC_STAGES{1'b0}};
            vin_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            vip_sync_q <= vip_sync_d;
            vin_sync_q <= vin_sync_d;
        end
    end

    // Candidate evaluation and saturating counter increment.
    always_comb begin
        vip_s     = vip_sync_q[SYNC_STAGES-1];
        vin_s     = vin_sync_q[SYNC_STAGES-1];
        differs_s = cand_differs(vip_s, vin_s, cmp_q);
        if (cnt_q == {DEB_W{1'b1}}) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + DEB_W'(1'b1);
        end
    end

    // Debounce next-state: a run of disagreeing advance samples toggles the
    // decision once the run exceeds deb_len; any agreeing or tie sample
    // breaks the run. ">=" lets a lowered deb_len finish a run at once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        changed_d = 1'b0;
        if (adv) begin
            case (state_q)
                STABLE: begin
                    if (differs_s) begin
                        if (deb_len == {DEB_W{1'b0}}) begin
                            cmp_d     = ~cmp_q;
                            changed_d = 1'b1;
                            state_d   = STABLE;
                        end else begin
                            cnt_d   = DEB_W'(1'b1);
                            state_d = PENDING;
                        end
                    end else begin
                        state_d = STABLE;
                    end
                end
                PENDING: begin
                    if (differs_s) begin
                        if (cnt_q >= deb_len) begin
                            cmp_d     = ~cmp_q;
                            changed_d = 1'b1;
                            cnt_d     = {DEB_W{1'b0}};
                            state_d   = STABLE;
                        end else begin
                            cnt_d   = cnt_inc_s;
                            state_d = PENDING;
                        end
                    end else begin
                        cnt_d   = {DEB_W{1'b0}};
                        state_d = STABLE;
                    end
                end
                default: begin
                    cnt_d   = {DEB_W{1'b0}};
                    state_d = STABLE;
                end
            endcase
        end else begin
            changed_d = 1'b0;
        end
    end

    // Debounce state machine and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STABLE;
            cnt_q     <= {DEB_W{1'b0}};
            cmp_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            changed_q <= changed_d;
        end
    end

    // Drive the channel outputs; tie is deliberately combinational.
    always_comb begin
        cmp_out = cmp_q;
        changed = changed_q;
        tie     = (vip_s == vin_s);
    end

endmodule

// File: rtl/semis_cmp_array.sv
// semis_cmp_array: CHANNELS independent debounced comparator channels sharing
// one clock, one enable and one advance qualifier.
module semis_cmp_array
    import semis_cmp_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int DEB_W       = DEF_DEB_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] vip,
    input  logic [CHANNELS-1:0] vin,
    input  logic                mode,
    input  logic                strobe,
    input  logic [DEB_W-1:0]    deb_len,
    output logic [CHANNELS-1:0] cmp_out,
    output logic [CHANNELS-1:0] changed,
    output logic [CHANNELS-1:0] tie
);

    logic adv_s;

    // One advance qualifier shared by every channel.
    always_comb begin
        adv_s = advance_ok(ena, mode, strobe);
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        semis_cmp_channel #(
            .DEB_W       (DEB_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv_s),
            .deb_len (deb_len),
            .vip     (vip[g]),
            .vin     (vin[g]),
            .cmp_out (cmp_out[g]),
            .changed (changed[g]),
            .tie     (tie[g])
        );
    end

endmodule

// File: tb/tb_semis_cmp_array.sv
// tb_semis_cmp_array: directed scenarios followed by randomized stimulus,
// each cycle compared against a behavioural run-length model.
module tb_semis_cmp_array;

    localparam int CH = 4;
    localparam int DW = 4;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [CH-1:0] vip;
    logic [CH-1:0] vin;
    logic          mode;
    logic          strobe;
    logic [DW-1:0] deb_len;
    logic [CH-1:0] cmp_out;
    logic [CH-1:0] changed;
    logic [CH-1:0] tie;

    int checks = 0;
    int errors = 0;

    // Reference model: pins delayed SS cycles, decision, pulse, run length.
    logic [CH-1:0] m_hv [SS];
    logic [CH-1:0] m_hn [SS];
    logic [CH-1:0] m_cmp;
    logic [CH-1:0] m_chg;
    int            m_run [CH];

    always #5 clk = ~clk;

    semis_cmp_array #(
        .CHANNELS    (CH),
        .DEB_W       (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .vip     (vip),
        .vin     (vin),
        .mode    (mode),
        .strobe  (strobe),
        .deb_len (deb_len),
        .cmp_out (cmp_out),
        .changed (changed),
        .tie     (tie)
    );

    task automatic check_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) begin
            m_hv[k] = '0;
            m_hn[k] = '0;
        end
        m_cmp = '0;
        m_chg = '0;
        for (int i = 0; i < CH; i++) m_run[i] = 0;
    endtask

    // One clock edge: advance the model with the pins seen at the edge, then
    // compare all outputs shortly after.
    task automatic step(input string tag);
        logic [CH-1:0] vs;
        logic [CH-1:0] ns;
        logic          adv;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            vs    = m_hv[SS-1];
            ns    = m_hn[SS-1];
            adv   = ena && (!mode || strobe);
            m_chg = '0;
            for (int i = 0; i < CH; i++) begin
                if (adv) begin
                    if (vs[i] != ns[i] && vs[i] != m_cmp[i]) begin
                        // Toggle when this sample makes the run longer than deb_len.
                        if (m_run[i] >= int'(deb_len)) begin
                            m_cmp[i] = ~m_cmp[i];
                            m_chg[i] = 1'b1;
                            m_run[i] = 0;
                        end else begin
                            m_run[i] = m_run[i] + 1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            for (int k = SS - 1; k > 0; k--) begin
                m_hv[k] = m_hv[k-1];
                m_hn[k] = m_hn[k-1];
            end
            m_hv[0] = vip;
            m_hn[0] = vin;
        end
        #1;
        check_vec({tag, " cmp_out"}, cmp_out, m_cmp);
        check_vec({tag, " changed"}, changed, m_chg);
        check_vec({tag, " tie"}, tie, ~(m_hv[SS-1] ^ m_hn[SS-1]));
    endtask

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        vip     = '0;
        vin     = '0;
        mode    = 1'b0;
        strobe  = 1'b0;
        deb_len = '0;
        model_reset();

        // Reset state before any clock edge.
        #2;
        check_vec("reset cmp_out", cmp_out, 4'b0000);
        check_vec("reset changed", changed, 4'b0000);
        check_vec("reset tie", tie, 4'b1111);
        step("in_reset");
        step("in_reset");

        // Unfiltered: ch0 resolves to 1 on the third edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        vip   = 4'b0001;
        vin   = 4'b0000;
        step("unf");
        step("unf");
        check_vec("unf before toggle", cmp_out, 4'b0000);
        step("unf");
        check_vec("unf toggle cmp_out", cmp_out, 4'b0001);
        check_vec("unf toggle changed", changed, 4'b0001);
        step("unf");
        check_vec("unf pulse ends", changed, 4'b0000);

        // Debounce reject: three disagreeing samples are not enough for deb_len=3.
        deb_len = 4'd3;
        vip     = 4'b0011;
        repeat (3) step("rej");
        vin = 4'b0010;
        repeat (6) step("rej");
        check_vec("rej cmp_out", cmp_out, 4'b0001);

        // Debounce accept with deb_len lowered mid-run.
        deb_len = 4'd5;
        vip     = 4'b0111;
        repeat (5) step("live");
        check_vec("live before drop", cmp_out, 4'b0001);
        deb_len = 4'd2;
        step("live");
        check_vec("live toggle cmp_out", cmp_out, 4'b0101);
        check_vec("live toggle changed", changed, 4'b0100);

        // Strobed mode, with ena low across one strobe.
        mode    = 1'b1;
        deb_len = 4'd1;
        vip     = 4'b1111;
        repeat (3) step("strb_sync");
        strobe = 1'b1;
        step("strb1");
        strobe = 1'b0;
        repeat (3) step("strb_gap");
        ena    = 1'b0;
        strobe = 1'b1;
        step("strb_dis");
        strobe = 1'b0;
        ena    = 1'b1;
        repeat (3) step("strb_gap");
        check_vec("strb frozen", cmp_out, 4'b0101);
        strobe = 1'b1;
        step("strb2");
        check_vec("strb toggle cmp_out", cmp_out, 4'b1101);
        check_vec("strb toggle changed", changed, 4'b1000);
        strobe = 1'b0;
        step("strb_after");

        // Tie hold on ch0.
        mode = 1'b0;
        vip  = 4'b1110;
        repeat (20) step("tie");
        check_vec("tie hold cmp_out", cmp_out, 4'b1101);
        check_vec("tie hold tie", tie, 4'b0011);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_vec("midrst cmp_out", cmp_out, 4'b0000);
                check_vec("midrst changed", changed, 4'b0000);
                check_vec("midrst tie", tie, 4'b1111);
                step("midrst");
                step("midrst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(7, 0) == 0) begin
                    vip[i] = 1'($urandom_range(1, 0));
                    vin[i] = 1'($urandom_range(1, 0));
                end
            end
            if ($urandom_range(39, 0) == 0) deb_len = DW'($urandom_range(5, 0));
            if ($urandom_range(49, 0) == 0) mode = ~mode;
            strobe = ($urandom_range(2, 0) == 0);
            ena    = ($urandom_range(9, 0) != 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/semis_cmp_array.md
# semis_cmp_array

Multi-channel clocked comparator front end, the successor to the single-pair latched comparator on the UABC tile. Each channel resolves a differential input pair (vip/vin) into a single bit, holding its last decision while the pair is at a tie. Each channel synchronises its pair, filters it with a programmable debounce count, and flags every output change. Sits between the tile's ui_in pins and the uo_out pins / downstream digital logic.

## Interface
- CHANNELS, default 4: number of independent comparator channels (1..8).
- DEB_W, default 4: debounce counter width; max debounce length 2^DEB_W-1.
- SYNC_STAGES, default 2: synchroniser flops per input (>=2).

- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ena  in  1  global enable; low freezes filter state, outputs and counters.
- vip  in  CHANNELS  positive inputs, asynchronous, one bit per channel.
- vin  in  CHANNELS  negative inputs, asynchronous, one bit per channel.
- mode  in  1  0 = continuous (filter advances every cycle); 1 = strobed (filter advances only on strobe).
- strobe  in  1  sample strobe, one-cycle pulses, synchronous to clk; ignored when mode=0.
- deb_len  in  DEB_W  required consecutive agreeing samples beyond the first; 0 = no filtering.
- cmp_out  out  CHANNELS  registered filtered decisions.
- changed  out  CHANNELS  one-cycle pulse on the cycle cmp_out[i] toggles.
- tie  out  CHANNELS  synchronised vip==vin (hold condition), combinational from the last sync stage.

## Operation
- Synchroniser: vip[i] and vin[i] each pass through SYNC_STAGES flops giving vip_s and vin_s.
- Candidate: vip_s=1, vin_s=0 -> 1; vip_s=0, vin_s=1 -> 0; vip_s==vin_s -> tie, no candidate.
- Advance condition adv = ena & (mode==0 | strobe).
- Per channel, FSM with states STABLE and PENDING, plus counter cnt[DEB_W].
- STABLE, adv, candidate != cmp_out:
  - if deb_len==0: toggle cmp_out, pulse changed, stay in STABLE;
  - else: cnt<=1, go to PENDING.
- PENDING, adv, candidate != cmp_out:
  - if cnt>=deb_len: toggle cmp_out, pulse changed, cnt<=0, go to STABLE (>= so a lowered deb_len takes effect immediately);
  - else: cnt<=cnt+1.
- PENDING, adv, candidate==cmp_out or tie: cnt<=0, go to STABLE (run broken).
- STABLE, tie or candidate==cmp_out: no change.
- No adv (ena=0, or mode=1 with strobe=0): state, cnt and cmp_out hold; changed=0.
- ena=0 does not stop the synchronisers.
- deb_len and mode are sampled every cycle; changing them mid-run never corrupts state. cnt saturates at 2^DEB_W-1; it cannot wrap.
- Channels are fully independent; simultaneous toggles on several channels give simultaneous changed pulses.

## Timing
- Reset (rst_n low, asynchronous):
  - cmp_out=0, changed=0, cnt=0, all FSMs in STABLE, sync flops=0;
  - tie therefore reads all-ones during and just after reset.
- Continuous mode, inputs stable from edge 0:
  - vip_s/vin_s valid after SYNC_STAGES edges;
  - cmp_out toggles on edge SYNC_STAGES+1+deb_len (default deb_len=0: edge 3).
- Strobed mode: toggle occurs on the (deb_len+1)-th strobe cycle with a valid candidate, after sync latency.
- changed is high for exactly the cycle following the toggling edge (registered, aligned with the new cmp_out value).
- Reset asserted mid-PENDING aborts the run; no changed pulse is emitted.
- After deassertion, first candidate evaluation is at edge SYNC_STAGES+1.

## Structure
- Package semis_cmp_pkg holds:
  - mode_e (CONTINUOUS=0, STROBED=1);
  - chan_state_e (STABLE, PENDING);
  - default parameter constants.
- Sub-module semis_cmp_channel: one synchroniser pair, candidate logic, FSM and counter.
  - The top generates CHANNELS instances and shares adv.
- Top-level tile wrapper mapping ui_in/uo_out is out of scope for this block.

## Test plan
- Reset check: rst_n low mid-run -> cmp_out=0, changed=0, tie=all-ones immediately, without waiting for a clk edge.
- Unfiltered: deb_len=0, mode=0, ch0 vip=1 vin=0 at edge 0 -> cmp_out[0]=1 after edge 3, changed[0] high one cycle only; other channels unchanged.
- Debounce reject: deb_len=3, ch1 toggles vip=1/vin=0 for 3 cycles then vin=vip=1 -> cmp_out[1] stays 0, no changed pulse.
- Debounce accept plus live change: deb_len=5, hold ch2 high-candidate; after cnt=3 drop deb_len to 2 -> toggle on the next adv cycle.
- Strobed mode: mode=1, deb_len=1, strobe every 4th cycle -> ch3 toggles on the 2nd strobe after sync; no change between strobes; ena=0 across a strobe freezes cnt.
- Tie hold: after cmp_out[0]=1, drive vip=vin=0 for 20 cycles -> cmp_out[0] stays 1, tie[0]=1 after 2 cycles.
